// File: rtl/mux_sel_pipe_pkg.sv
// Shared definitions for the registered channel selector.
//   clog2        : constant function for index widths
//   DEF_NUM_IN   : default channel count
//   DEF_WIDTH    : default data width
//   MODE_FIXED / MODE_RR : rr_mode encodings
//   out_state_e  : output register occupancy
package mux_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  localparam int DEF_NUM_IN = 4;
  localparam int DEF_WIDTH  = 32;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/mux_sel_pipe_if.sv
// Handshake bundle between the channel sources, the selector and the
// downstream consumer.
//   in_data/in_valid/in_ready : per-channel input side
//   rr_mode/sel               : selection control
//   out_data/out_chan/out_valid/out_ready : registered output side
// slave  : the selector's view
// master : the environment's view
interface mux_sel_pipe_if #(
  parameter int NUM_IN = mux_pkg::DEF_NUM_IN,
  parameter int WIDTH  = mux_pkg::DEF_WIDTH
);
  localparam int SEL_W = mux_pkg::clog2(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic                    rr_mode;
  logic [SEL_W-1:0]        sel;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_chan;
  logic                    out_valid;
  logic                    out_ready;

  modport slave (
    input  in_data, in_valid, rr_mode, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

  modport master (
    output in_data, in_valid, rr_mode, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/mux_sel_pipe_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : per-channel request
//   ptr     : highest-priority channel index (always < NUM_IN)
//   gnt     : one-hot grant
//   gnt_idx : index of the granted channel
//   any_gnt : some channel is granted
module rr_arbiter import mux_pkg::*; #(
  parameter int NUM_IN = DEF_NUM_IN
) (
  input  logic [NUM_IN-1:0]        req,
  input  logic [clog2(NUM_IN)-1:0] ptr,
  output logic [NUM_IN-1:0]        gnt,
  output logic [clog2(NUM_IN)-1:0] gnt_idx,
  output logic                     any_gnt
);
  localparam int SEL_W = clog2(NUM_IN);

  always_comb begin
    int unsigned idx;
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = 0;
    // Walk ptr, ptr+1, ... modulo NUM_IN; first requester wins.
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      idx = (32'(ptr) + i) % NUM_IN;
      if (!any_gnt && req[idx]) begin
        any_gnt  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = SEL_W'(idx);
      end
    end
  end
endmodule

// File: rtl/mux_sel_pipe.sv
// Registered NUM_IN:1 channel selector with valid/ready handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux_sel_pipe_if.slave (channel inputs, select controls,
//           registered output with handshake)
// Fixed mode grants bus.sel when it is a valid in-range channel; round-robin
// mode grants the first requester at or after rr_ptr.
module mux_sel_pipe import mux_pkg::*; #(
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int WIDTH  = DEF_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_sel_pipe_if.slave bus
);
  localparam int SEL_W = clog2(NUM_IN);

  out_state_e        state_q, state_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_chan_q, out_chan_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [NUM_IN-1:0] arb_gnt, fix_gnt, grant_vec;
  logic [SEL_W-1:0]  arb_idx, fix_idx, grant_idx;
  logic              arb_any, fix_any, grant_any;
  logic              out_valid, can_load, xfer;
  logic [WIDTH-1:0]  grant_data;

  rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
    .req     (bus.in_valid),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any_gnt (arb_any)
  );

  // Compare against every legal index instead of indexing in_valid[sel],
  // so an out-of-range sel simply matches nothing.
  always_comb begin
    fix_gnt = '0;
    fix_idx = '0;
    fix_any = 1'b0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (bus.sel == SEL_W'(k) && bus.in_valid[k]) begin
        fix_gnt[k] = 1'b1;
        fix_idx    = SEL_W'(k);
        fix_any    = 1'b1;
      end
    end
  end

  always_comb begin
    if (bus.rr_mode == MODE_RR) begin
      grant_vec = arb_gnt;
      grant_idx = arb_idx;
      grant_any = arb_any;
    end else begin
      grant_vec = fix_gnt;
      grant_idx = fix_idx;
      grant_any = fix_any;
    end
  end

  always_comb begin
    grant_data = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (grant_idx == SEL_W'(k)) grant_data = bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  assign can_load     = !out_valid || bus.out_ready;
  assign xfer         = grant_any && can_load;
  assign bus.in_ready = (rst_n && can_load) ? grant_vec : '0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_chan_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_chan_d = out_chan_q;
    rr_ptr_d   = rr_ptr_q;
    if (xfer) begin
      state_d    = FULL;
      out_data_d = grant_data;
      out_chan_d = grant_idx;
      if (bus.rr_mode == MODE_RR) begin
        rr_ptr_d = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + SEL_W'(1);
      end
    end else if (out_valid && bus.out_ready) begin
      state_d = EMPTY;
    end
  end

  // Output logic
  always_comb begin
    out_valid = (state_q == FULL);
  end

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
endmodule

// File: tb/tb_mux_sel_pipe.sv
module tb_mux_sel_pipe;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mux_sel_pipe_if #(.NUM_IN(4), .WIDTH(32)) bus4 ();
  mux_sel_pipe_if #(.NUM_IN(3), .WIDTH(32)) bus3 ();

  mux_sel_pipe #(.NUM_IN(4), .WIDTH(32)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  mux_sel_pipe #(.NUM_IN(3), .WIDTH(32)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the 4-channel instance
  bit          m_valid;
  logic [31:0] m_data;
  int          m_chan;
  int          m_ptr;

  function automatic int ref_grant(logic [15:0] v, bit rr, int s, int p, int n);
    if (!rr) return (s < n && v[s]) ? s : -1;
    for (int i = 0; i < n; i++) if (v[(p + i) % n]) return (p + i) % n;
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready4();
    int g;
    g = ref_grant({12'b0, bus4.in_valid}, bus4.rr_mode, int'(bus4.sel), m_ptr, 4);
    if (g >= 0 && (!m_valid || bus4.out_ready)) return 4'(1 << g);
    return 4'b0;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = 0;
    m_ptr   = 0;
  endtask

  // Advance one clock and update the model from the inputs held this cycle.
  task automatic tick4();
    int g;
    bit can;
    g   = ref_grant({12'b0, bus4.in_valid}, bus4.rr_mode, int'(bus4.sel), m_ptr, 4);
    can = !m_valid || bus4.out_ready;
    @(posedge clk);
    if (g >= 0 && can) begin
      m_data  = bus4.in_data[g*32 +: 32];
      m_chan  = g;
      m_valid = 1'b1;
      if (bus4.rr_mode) m_ptr = (g + 1) % 4;
    end else if (m_valid && bus4.out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic rand_data4();
    for (int i = 0; i < 4; i++) bus4.in_data[i*32 +: 32] = $urandom;
  endtask

  task automatic test_reset();
    bus4.in_valid = 4'b1111; bus4.out_ready = 1'b1; bus4.rr_mode = 1'b1;
    bus3.in_valid = 3'b111;  bus3.out_ready = 1'b1; bus3.rr_mode = 1'b1;
    #3;
    checks++; if (bus4.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus4.out_valid); end
    checks++; if (bus4.out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", bus4.out_data); end
    checks++; if (bus4.out_chan !== 2'd0) begin failures++; $display("FAIL reset_out_chan got=%0d exp=0", bus4.out_chan); end
    checks++; if (bus4.in_ready !== 4'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0000", bus4.in_ready); end
    checks++; if (bus3.in_ready !== 3'b0) begin failures++; $display("FAIL reset_in_ready3 got=%b exp=000", bus3.in_ready); end
    bus4.in_valid = '0;
    bus3.in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_fixed();
    rand_data4();
    bus4.in_data[2*32 +: 32] = 32'hDEAD_BEEF;
    bus4.rr_mode = 1'b0; bus4.sel = 2'd2; bus4.in_valid = 4'b1111; bus4.out_ready = 1'b1;
    #1;
    checks++; if (bus4.in_ready !== 4'b0100) begin failures++; $display("FAIL fixed_in_ready got=%b exp=0100", bus4.in_ready); end
    tick4();
    checks++; if (bus4.out_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL fixed_out_data got=%h exp=deadbeef", bus4.out_data); end
    checks++; if (bus4.out_chan !== 2'd2) begin failures++; $display("FAIL fixed_out_chan got=%0d exp=2", bus4.out_chan); end
    checks++; if (bus4.out_valid !== 1'b1) begin failures++; $display("FAIL fixed_out_valid got=%b exp=1", bus4.out_valid); end
  endtask

  task automatic test_rr_rotate();
    bus4.rr_mode = 1'b1; bus4.in_valid = 4'b1111; bus4.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_data4();
      #1;
      checks++; if (bus4.in_ready !== 4'(1 << (i % 4))) begin failures++; $display("FAIL rr_rotate_ready[%0d] got=%b exp=%b", i, bus4.in_ready, 4'(1 << (i % 4))); end
      tick4();
      checks++; if (bus4.out_chan !== 2'(i % 4)) begin failures++; $display("FAIL rr_rotate_chan[%0d] got=%0d exp=%0d", i, bus4.out_chan, i % 4); end
      checks++; if (bus4.out_data !== m_data || bus4.out_valid !== 1'b1) begin failures++; $display("FAIL rr_rotate_data[%0d] got=%h/%b exp=%h/1", i, bus4.out_data, bus4.out_valid, m_data); end
    end
  endtask

  task automatic test_rr_wrap_skip();
    int exp_g [3] = '{0, 2, 0};
    bus4.rr_mode = 1'b1; bus4.out_ready = 1'b1; bus4.in_valid = 4'b0100;
    rand_data4();
    tick4();
    checks++; if (bus4.out_chan !== 2'd2) begin failures++; $display("FAIL wrap_setup_chan got=%0d exp=2", bus4.out_chan); end
    bus4.in_valid = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      rand_data4();
      #1;
      checks++; if (bus4.in_ready !== 4'(1 << exp_g[i])) begin failures++; $display("FAIL wrap_ready[%0d] got=%b exp=%b", i, bus4.in_ready, 4'(1 << exp_g[i])); end
      tick4();
      checks++; if (bus4.out_chan !== 2'(exp_g[i]) || bus4.out_data !== m_data) begin failures++; $display("FAIL wrap_chan[%0d] got=%0d/%h exp=%0d/%h", i, bus4.out_chan, bus4.out_data, exp_g[i], m_data); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d3;
    rand_data4();
    bus4.in_data[1*32 +: 32] = 32'h1234_5678;
    bus4.rr_mode = 1'b0; bus4.sel = 2'd1; bus4.in_valid = 4'b0010; bus4.out_ready = 1'b1;
    tick4();
    checks++; if (bus4.out_data !== 32'h1234_5678) begin failures++; $display("FAIL bp_load got=%h exp=12345678", bus4.out_data); end
    bus4.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_data4();
      bus4.in_valid = 4'($urandom);
      bus4.rr_mode  = 1'($urandom);
      bus4.sel      = 2'($urandom);
      #1;
      checks++; if (bus4.in_ready !== 4'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b exp=0000", i, bus4.in_ready); end
      tick4();
      checks++; if (bus4.out_data !== 32'h1234_5678 || bus4.out_chan !== 2'd1 || bus4.out_valid !== 1'b1) begin
        failures++; $display("FAIL bp_hold[%0d] got=%h/%0d/%b exp=12345678/1/1", i, bus4.out_data, bus4.out_chan, bus4.out_valid);
      end
    end
    rand_data4();
    d3 = bus4.in_data[3*32 +: 32];
    bus4.out_ready = 1'b1; bus4.rr_mode = 1'b0; bus4.sel = 2'd3; bus4.in_valid = 4'b1000;
    #1;
    checks++; if (bus4.in_ready !== 4'b1000) begin failures++; $display("FAIL bp_release_ready got=%b exp=1000", bus4.in_ready); end
    tick4();
    checks++; if (bus4.out_data !== d3 || bus4.out_chan !== 2'd3 || bus4.out_valid !== 1'b1) begin
      failures++; $display("FAIL bp_drain_load got=%h/%0d/%b exp=%h/3/1", bus4.out_data, bus4.out_chan, bus4.out_valid, d3);
    end
    bus4.in_valid = 4'b0;
    tick4();
    checks++; if (bus4.out_valid !== 1'b0 || bus4.out_data !== d3 || bus4.out_chan !== 2'd3) begin
      failures++; $display("FAIL drain_only got=%b/%h/%0d exp=0/%h/3", bus4.out_valid, bus4.out_data, bus4.out_chan, d3);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_data4();
      bus4.in_valid  = 4'($urandom);
      bus4.rr_mode   = ($urandom_range(0, 3) != 0);
      bus4.sel       = 2'($urandom);
      bus4.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++; if (bus4.in_ready !== exp_ready4()) begin failures++; $display("FAIL rand_ready[%0d] got=%b exp=%b", i, bus4.in_ready, exp_ready4()); end
      tick4();
      checks++; if (bus4.out_valid !== m_valid || bus4.out_data !== m_data || bus4.out_chan !== 2'(m_chan)) begin
        failures++; $display("FAIL rand_out[%0d] got=%b/%h/%0d exp=%b/%h/%0d", i, bus4.out_valid, bus4.out_data, bus4.out_chan, m_valid, m_data, m_chan);
      end
    end
  endtask

  task automatic test_mid_reset();
    rand_data4();
    bus4.rr_mode = 1'b1; bus4.out_ready = 1'b1; bus4.in_valid = 4'b0010;
    tick4();
    checks++; if (bus4.out_valid !== 1'b1) begin failures++; $display("FAIL midrst_setup got=%b exp=1", bus4.out_valid); end
    bus4.in_valid = 4'b1111;
    rst_n = 1'b0;
    #1;
    checks++; if (bus4.out_valid !== 1'b0 || bus4.out_data !== 32'h0 || bus4.out_chan !== 2'd0) begin
      failures++; $display("FAIL midrst_out got=%b/%h/%0d exp=0/0/0", bus4.out_valid, bus4.out_data, bus4.out_chan);
    end
    checks++; if (bus4.in_ready !== 4'b0) begin failures++; $display("FAIL midrst_in_ready got=%b exp=0000", bus4.in_ready); end
    bus4.in_valid = 4'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    bus4.in_valid = 4'b1111;
    rand_data4();
    #1;
    checks++; if (bus4.in_ready !== 4'b0001) begin failures++; $display("FAIL midrst_ptr got=%b exp=0001", bus4.in_ready); end
    tick4();
    checks++; if (bus4.out_chan !== 2'd0 || bus4.out_data !== m_data) begin failures++; $display("FAIL midrst_first got=%0d/%h exp=0/%h", bus4.out_chan, bus4.out_data, m_data); end
    bus4.in_valid = 4'b0;
    tick4();
  endtask

  task automatic test_small_n();
    logic [31:0] d1;
    int exp_c [5] = '{0, 1, 2, 0, 1};
    for (int i = 0; i < 3; i++) bus3.in_data[i*32 +: 32] = $urandom;
    d1 = bus3.in_data[1*32 +: 32];
    bus3.rr_mode = 1'b0; bus3.sel = 2'd3; bus3.in_valid = 3'b111; bus3.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus3.in_ready !== 3'b0 || $isunknown(bus3.in_ready)) begin failures++; $display("FAIL n3_sel3_ready[%0d] got=%b exp=000", i, bus3.in_ready); end
      @(posedge clk); #1;
      checks++; if (bus3.out_valid !== 1'b0 || $isunknown({bus3.out_data, bus3.out_chan, bus3.out_valid})) begin
        failures++; $display("FAIL n3_sel3_out[%0d] got=%b/%h/%0d exp=0 no X", i, bus3.out_valid, bus3.out_data, bus3.out_chan);
      end
    end
    bus3.sel = 2'd1;
    #1;
    checks++; if (bus3.in_ready !== 3'b010) begin failures++; $display("FAIL n3_sel1_ready got=%b exp=010", bus3.in_ready); end
    @(posedge clk); #1;
    checks++; if (bus3.out_valid !== 1'b1 || bus3.out_chan !== 2'd1 || bus3.out_data !== d1) begin
      failures++; $display("FAIL n3_sel1_out got=%b/%0d/%h exp=1/1/%h", bus3.out_valid, bus3.out_chan, bus3.out_data, d1);
    end
    bus3.rr_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (bus3.out_chan !== 2'(exp_c[i])) begin failures++; $display("FAIL n3_rr_chan[%0d] got=%0d exp=%0d", i, bus3.out_chan, exp_c[i]); end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    bus4.in_data = '0; bus4.in_valid = '0; bus4.rr_mode = 1'b0; bus4.sel = '0; bus4.out_ready = 1'b0;
    bus3.in_data = '0; bus3.in_valid = '0; bus3.rr_mode = 1'b0; bus3.sel = '0; bus3.out_ready = 1'b0;
    model_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    test_reset();
    test_fixed();
    test_rr_rotate();
    test_rr_wrap_skip();
    test_backpressure();
    test_random();
    test_mid_reset();
    test_small_n();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_sel_pipe.md
Name: mux_sel_pipe

Overview:
- Parametrised, registered successor to the team's gate-level 4:1 selector.
- Selects one of NUM_IN channels of WIDTH bits and holds the result in an output register with a valid/ready handshake.
- Two selection modes: fixed (external select) and round-robin arbitration.
- Feeds the 32-bit ALU result path, where several functional units compete for one writeback/output bus.

Parameters:
- NUM_IN, 4, number of input channels (2..16).
- WIDTH, 32, data width per channel.
- SEL_W, clog2(NUM_IN), select/channel-index width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  NUM_IN*WIDTH  channel data; channel k occupies bits [k*WIDTH +: WIDTH]
- in_valid  in  NUM_IN  per-channel valid
- in_ready  out  NUM_IN  per-channel ready; at most one bit high per cycle
- rr_mode  in  1  0 = fixed select, 1 = round-robin
- sel  in  SEL_W  channel index used in fixed mode
- out_data  out  WIDTH  registered selected data
- out_chan  out  SEL_W  index of the channel that produced out_data
- out_valid  out  1  output register holds data
- out_ready  in  1  downstream accepts

Behaviour:
- Reset (async assert, synchronous-to-clk release):
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer rr_ptr=0.
  - in_ready outputs all 0 while rst_n=0.
- Output register state:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Capacity and transfers:
  - can_load = !out_valid || out_ready (combinational).
  - Full throughput: one transfer per cycle, with 1-cycle latency from input handshake to out_valid.
  - Input transfer on channel k when in_valid[k] && in_ready[k] at a rising edge.
  - Output transfer when out_valid && out_ready.
- Grant, fixed mode (rr_mode=0):
  - grant = sel if sel < NUM_IN and in_valid[sel]=1; otherwise no grant.
  - sel >= NUM_IN (non-power-of-2 NUM_IN) never grants and never drives X.
  - rr_ptr does not change.
- Grant, round-robin mode (rr_mode=1):
  - grant = first k with in_valid[k]=1, searching rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_IN.
  - On an input transfer from channel k, rr_ptr <= (k+1) mod NUM_IN. For k = NUM_IN-1, the pointer wraps to 0.
  - No transfer leaves rr_ptr unchanged.
- Readiness:
  - in_ready[grant] = can_load; all other in_ready bits are 0.
  - in_ready may depend combinationally on in_valid, sel, rr_mode and out_ready.
  - Upstream must not make valid depend on ready.
- State update on each clock edge:
  - Input transfer (with or without a simultaneous output transfer): out_data <= granted data, out_chan <= grant, out_valid <= 1.
  - Output transfer without input transfer: out_valid <= 0. out_data and out_chan hold their stale values.
  - Neither: all registers hold.
  - While out_valid=1 && out_ready=0, out_data and out_chan are stable and in_ready is all 0 (no overwrite).
- Mode and select changes:
  - rr_mode and sel are sampled combinationally every cycle.
  - A change takes effect on the next grant. It never affects data already registered.
- Reset mid-operation: registered data is dropped, out_valid falls immediately (asynchronously), and rr_ptr returns to 0.
- Width rules: no arithmetic on data. Pointer increment is modulo NUM_IN, not modulo 2^SEL_W.

Decomposition:
- Package mux_pkg:
  - clog2 constant function.
  - Default NUM_IN and WIDTH constants.
  - Mode encoding constants MODE_FIXED=0 and MODE_RR=1.
- Sub-module rr_arbiter (NUM_IN): combinational.
  - Inputs: req and ptr.
  - Outputs: one-hot gnt, gnt_idx and any_gnt.
- mux_sel_pipe instantiates rr_arbiter and contains the fixed-select decode, the data mux, the output register and rr_ptr.

Test Plan:
- Reset: assert rst_n=0 mid-burst with out_valid=1 -> out_valid, out_data and out_chan read 0 before the next clk edge, and in_ready=0. After release, rr_ptr=0.
- Fixed mode, sel=2, in_valid=4'b1111, channel 2 data=32'hDEAD_BEEF, out_ready=1 -> only in_ready[2]=1; the next cycle gives out_data=32'hDEAD_BEEF, out_chan=2, out_valid=1.
- Round-robin, all four valid for 8 cycles, out_ready=1 -> out_chan sequence 0,1,2,3,0,1,2,3 with one transfer per cycle.
- Round-robin wrap and skip: rr_ptr=3, in_valid=4'b0101 -> grant 0 (wrap past 3), then grant 2, then grant 0.
- Backpressure: output full with out_data=32'h1234_5678 and out_ready=0 for 5 cycles while inputs change -> out_data and out_chan stable and in_ready=0 throughout. Raising out_ready yields a simultaneous drain and load in one cycle.
- NUM_IN=3, fixed mode, sel=3 with in_valid=3'b111 -> no grant, in_ready=0, out_valid stays 0, no X on any output.
